softmax_normalize: RTL and testbench



---
 rtl/softmax_normalize_if.sv | 61 ++++++
 rtl/softmax_normalize.sv | 202 ++++++++++++++++++++
 tb/tb_softmax_normalize.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_normalize_if.sv
// ---------------------------------------------------------------------------
// softmax_normalize_if
// Stream bundle for the Softermax normalization stage.
//
// Input side (producer -> block):
//   in_valid  : vector and sum presented
//   in_ready  : block can accept (block drives)
//   vec_in    : VEC_SIZE unsigned exponentials, element i at vec_in[i]
//   sum_in    : reduced sum of vec_in
// Output side (block -> consumer):
//   out_valid : out_data valid (block drives)
//   out_ready : consumer accepts out_data
//   out_data  : normalized probability
//   out_idx   : element index of out_data
//   out_last  : high with the final element of the vector
//
// Modports: slave = the normalization block, master = the surrounding logic
// (upstream producer plus downstream consumer).
// ---------------------------------------------------------------------------
interface softmax_normalize_if #(
    parameter int BW       = 16,
    parameter int SUM_BW   = 16,
    parameter int P_BW     = 16,
    parameter int VEC_SIZE = 5
);
    localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [VEC_SIZE-1:0][BW-1:0]   vec_in;
    logic [SUM_BW-1:0]             sum_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [P_BW-1:0]               out_data;
    logic [IDX_W-1:0]              out_idx;
    logic                          out_last;

    modport slave (
        input  in_valid,
        input  vec_in,
        input  sum_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output vec_in,
        output sum_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/softmax_normalize.sv
// ---------------------------------------------------------------------------
// softmax_normalize
// Final normalization stage of the Softermax datapath. Accepts one vector of
// unnormalized exponentials plus their reduced sum, computes the reciprocal
// of the sum by bit-serial restoring division (one quotient bit per cycle),
// then streams out vec[i] * (1/sum) one element per output handshake.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, returns the block to IDLE
//   bus  : softmax_normalize_if.slave
//          in_valid/in_ready/vec_in/sum_in  - input vector handshake
//          out_valid/out_ready/out_data/out_idx/out_last - output stream
// ---------------------------------------------------------------------------
module softmax_normalize #(
    parameter int BW       = 16,
    parameter int FW       = 15,
    parameter int SUM_BW   = 16,
    parameter int SUM_FW   = 6,
    parameter int RFW      = 16,
    parameter int P_BW     = 16,
    parameter int P_FW     = 15,
    parameter int VEC_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    softmax_normalize_if.slave    bus
);
    // Quotient width: dividend is 2^(RFW+SUM_FW), so the quotient needs one
    // bit more than the dividend exponent to hold the sum==1 LSB case.
    localparam int QW    = RFW + SUM_FW + 1;
    localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;
    localparam int PW    = BW + QW;
    localparam int SHIFT = FW + RFW - P_FW;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(QW - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [BW-1:0]      r_vec [VEC_SIZE];
    logic [SUM_BW-1:0]  r_sum;
    logic [QW-1:0]      r_recip;
    logic [SUM_BW-1:0]  r_rem;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]   r_idx;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_div_bit;
    logic [SUM_BW:0]    w_rem_shift;
    logic               w_q_bit;
    logic [BW-1:0]      w_sel_vec;
    logic [PW-1:0]      w_prod;
    logic [PW-1:0]      w_shifted;
    logic [P_BW-1:0]    w_data;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (r_idx == LAST_IDX);
                if (bus.out_ready && (r_idx == LAST_IDX)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_in_fire  = (r_state == S_IDLE) && bus.in_valid;
    assign w_out_fire = (r_state == S_EMIT) && bus.out_ready;

    // -----------------------------------------------------------------------
    // Input capture: only the IDLE handshake writes the vector registers, so
    // the producer may change vec_in freely once the vector is accepted.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < VEC_SIZE; gi++) begin : g_vec_reg
            always_ff @(posedge clk) begin
                if (w_in_fire) begin
                    r_vec[gi] <= bus.vec_in[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Restoring division of 2^(QW-1) by r_sum, MSB first. The dividend is a
    // single one followed by zeros, so the bit shifted into the partial
    // remainder is 1 only on the first step.
    // With r_sum==0 every trial subtract succeeds and the quotient saturates
    // to all ones; the remainder wraps but is never observed.
    // -----------------------------------------------------------------------
    assign w_div_bit   = (r_bit_cnt == '0);
    assign w_rem_shift = {r_rem, w_div_bit};
    assign w_q_bit     = (w_rem_shift >= {1'b0, r_sum});

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_sum     <= bus.sum_in;
            r_recip   <= '0;
            r_rem     <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == S_DIVIDE) begin
            r_recip   <= {r_recip[QW-2:0], w_q_bit};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_q_bit) begin
                r_rem <= SUM_BW'(w_rem_shift - {1'b0, r_sum});
            end else begin
                r_rem <= w_rem_shift[SUM_BW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Element index: reset-controlled so a restart always begins at 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_in_fire) begin
            r_idx <= '0;
        end else if (w_out_fire) begin
            if (r_idx == LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output datapath: purely combinational from registered state, so it
    // holds steady under backpressure.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel_vec = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_vec = r_vec[i];
            end
        end
    end

    assign w_prod    = PW'(w_sel_vec) * PW'(r_recip);
    assign w_shifted = w_prod >> SHIFT;

    generate
        if (PW > P_BW) begin : g_sat
            // Any set bit above the output width means the probability does
            // not fit; clamp to full scale rather than wrap.
            assign w_data = (|w_shifted[PW-1:P_BW]) ? {P_BW{1'b1}}
                                                    : w_shifted[P_BW-1:0];
        end else begin : g_nosat
            assign w_data = P_BW'(w_shifted);
        end
    endgenerate

    assign bus.out_data = w_data;
    assign bus.out_idx  = r_idx;

endmodule

// File: tb/tb_softmax_normalize.sv
module tb_softmax_normalize;
    localparam int BW       = 16;
    localparam int FW       = 15;
    localparam int SUM_BW   = 16;
    localparam int SUM_FW   = 6;
    localparam int RFW      = 16;
    localparam int P_BW     = 16;
    localparam int P_FW     = 15;
    localparam int VS       = 5;
    localparam int QW       = RFW + SUM_FW + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    softmax_normalize_if #(.BW(BW), .SUM_BW(SUM_BW), .P_BW(P_BW), .VEC_SIZE(VS)) u_if ();

    softmax_normalize #(
        .BW(BW), .FW(FW), .SUM_BW(SUM_BW), .SUM_FW(SUM_FW), .RFW(RFW),
        .P_BW(P_BW), .P_FW(P_FW), .VEC_SIZE(VS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    exp_t        sb_q[$];
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          accept_cnt = 0;
    bit          bp_mode    = 1'b0;
    bit          held_valid = 1'b0;
    logic [15:0] held_data;
    logic [2:0]  held_idx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer division for the reciprocal, then scale.
    function automatic logic [15:0] model_p(input logic [15:0] v, input logic [15:0] s);
        logic [22:0] r;
        logic [38:0] p;
        logic [38:0] sh;
        if (s == 16'd0) r = 23'h7FFFFF;
        else            r = 23'((64'd1 << 22) / 64'(s));
        p  = 39'(v) * 39'(r);
        sh = p >> 16;
        return (sh[38:16] != '0) ? 16'hFFFF : sh[15:0];
    endfunction

    // Consumer ready: always 1, or random when backpressure mode is on.
    initial begin
        u_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_valid = 1'b0;
            end else begin
                if (u_if.out_valid)
                    check_val("in_ready_during_emit", 32'(u_if.in_ready), 32'd0);
                if (held_valid) begin
                    check_val("hold_valid", 32'(u_if.out_valid), 32'd1);
                    check_val("hold_data", 32'(u_if.out_data), 32'(held_data));
                    check_val("hold_idx", 32'(u_if.out_idx), 32'(held_idx));
                end
                if (u_if.out_valid && u_if.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("spurious_out", 32'(u_if.out_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_val("out_data", 32'(u_if.out_data), 32'(e.data));
                        check_val("out_idx", 32'(u_if.out_idx), 32'(e.idx));
                        check_val("out_last", 32'(u_if.out_last), 32'(e.last));
                        $display("[TB] out idx=%0d data=0x%04h last=%0d exp=0x%04h",
                                 u_if.out_idx, u_if.out_data, u_if.out_last, e.data);
                    end
                    accept_cnt++;
                end
                held_valid = u_if.out_valid && !u_if.out_ready;
                held_data  = u_if.out_data;
                held_idx   = u_if.out_idx;
            end
        end
    end

    task automatic send_vec(input logic [VS-1:0][15:0] v, input logic [15:0] s, input bit meas);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!u_if.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check_val("in_ready_timeout", 32'(u_if.in_ready), 32'd1);
                return;
            end
        end
        u_if.in_valid = 1'b1;
        u_if.vec_in   = v;
        u_if.sum_in   = s;
        for (int i = 0; i < VS; i++) begin
            e.data = model_p(v[i], s);
            e.idx  = 3'(i);
            e.last = (i == VS - 1);
            sb_q.push_back(e);
        end
        $display("[TB] send sum=0x%04h v0=0x%04h v1=0x%04h v2=0x%04h v3=0x%04h v4=0x%04h",
                 s, v[0], v[1], v[2], v[3], v[4]);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        // Scramble inputs after acceptance; outputs must not change.
        for (int i = 0; i < VS; i++) u_if.vec_in[i] = 16'($urandom);
        u_if.sum_in = 16'($urandom);
        if (meas) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!u_if.out_valid && n < 100);
            check_val("first_valid_latency", 32'(n), 32'(QW + 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || !u_if.in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        #0;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_out_valid"}, 32'(u_if.out_valid), 32'd0);
        check_val({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
        check_val({tag, "_idx"}, 32'(u_if.out_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [VS-1:0][15:0] v;
        logic [15:0]         s;
        int                  base;
        int                  n;

        rst           = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.vec_in   = '0;
        u_if.sum_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_out_valid", 32'(u_if.out_valid), 32'd0);
        check_val("reset_in_ready", 32'(u_if.in_ready), 32'd1);
        check_val("reset_idx", 32'(u_if.out_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // sum = 1.0: identity scaling, latency measured.
        v[0] = 16'h4000; v[1] = 16'h8000; v[2] = 16'h0000; v[3] = 16'h0001; v[4] = 16'h7FFF;
        send_vec(v, 16'd64, 1'b1);
        drain();

        // sum = 3.0: every element 0x5555 -> 0x1C71.
        for (int i = 0; i < VS; i++) v[i] = 16'h5555;
        send_vec(v, 16'd192, 1'b0);
        drain();

        // sum = 1 LSB: huge reciprocal, saturation on vec[1].
        v[0] = 16'h0100; v[1] = 16'h8000; v[2] = 16'h0010; v[3] = 16'h0000; v[4] = 16'h0002;
        send_vec(v, 16'd1, 1'b0);
        drain();

        // sum = 0: reciprocal saturates to all ones.
        v[0] = 16'h0000; v[1] = 16'h0001; v[2] = 16'h8000; v[3] = 16'h0002; v[4] = 16'h0123;
        send_vec(v, 16'd0, 1'b0);
        drain();

        // Random vectors under random backpressure, sent back to back.
        bp_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < VS; i++) v[i] = 16'($urandom);
            case (k)
                0:       s = 16'd0;
                1:       s = 16'($urandom_range(1, 63));
                default: s = 16'($urandom_range(1, 65535));
            endcase
            send_vec(v, s, 1'b0);
        end
        drain();
        bp_mode = 1'b0;

        // Reset in the middle of DIVIDE (cycle E+10).
        for (int i = 0; i < VS; i++) v[i] = 16'($urandom);
        send_vec(v, 16'd100, 1'b0);
        repeat (9) @(posedge clk);
        pulse_reset_and_check("rst_divide");
        for (int i = 0; i < VS; i++) v[i] = 16'($urandom);
        send_vec(v, 16'd320, 1'b1);
        drain();

        // Reset in the middle of EMIT, right after idx 2 is accepted.
        base = accept_cnt;
        for (int i = 0; i < VS; i++) v[i] = 16'($urandom);
        send_vec(v, 16'd77, 1'b0);
        n = 0;
        while (accept_cnt < base + 3 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check_val("emit_progress", 32'(accept_cnt - base), 32'd3);
        #1;
        pulse_reset_and_check("rst_emit");
        for (int i = 0; i < VS; i++) v[i] = 16'($urandom);
        send_vec(v, 16'd640, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
